data_path: RTL and testbench

- 32-bit single-bus CPU datapath: sixteen GPRs R0–R15, HI, LO, PC, IR, MAR, MDR, Y and a 64-bit Z register, plus an ALU.
- All registers share one 32-bit bus (BusMuxOut) selected by one-hot "out" strobes.
- The control unit (or a bench FSM) sequences the strobes.
- Memory read data enters on the IN port.

---
 rtl/data_path_if.sv | 42 ++++
 rtl/data_path.sv | 111 +++++++++++
 tb/tb_data_path.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_path_if.sv
// Datapath control/bus bundle: controller-side strobes and selects in, bus and PC views out.
// Purely combinational signal grouping; no state, no flow control.
interface data_path_if #(
    parameter int WIDTH = 32
);
    // Bus source selects
    logic [15:0]      Rout;
    logic             HIout, LOout, Zhighout, Zlowout, PCout, IRout;
    logic             MDRout, INout, Cout, Yout, MARout;
    // Register load enables
    logic [15:0]      Rin;
    logic             HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin;
    // MDR source and PC increment selects
    logic             Read, IncPC;
    // ALU op selects
    logic             ADD, SUB, AND, OR, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
    // Data
    logic [WIDTH-1:0] IN;
    logic [WIDTH-1:0] BusMuxOut;
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] PC_PLUS_1;

    modport master (
        output Rout, HIout, LOout, Zhighout, Zlowout, PCout, IRout,
        output MDRout, INout, Cout, Yout, MARout,
        output Rin, HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin,
        output Read, IncPC,
        output ADD, SUB, AND, OR, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
        output IN,
        input  BusMuxOut, PC, PC_PLUS_1
    );

    modport slave (
        input  Rout, HIout, LOout, Zhighout, Zlowout, PCout, IRout,
        input  MDRout, INout, Cout, Yout, MARout,
        input  Rin, HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin,
        input  Read, IncPC,
        input  ADD, SUB, AND, OR, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
        input  IN,
        output BusMuxOut, PC, PC_PLUS_1
    );
endinterface

// File: rtl/data_path.sv
// Single-bus CPU datapath: R0-R15, HI, LO, PC, IR, MAR, MDR, Y, 64-bit Z and a combinational ALU.
// Bus and ALU are zero-latency; register loads take one edge; no backpressure, strobes are obeyed every cycle.
module data_path #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    data_path_if.slave dp
);
    localparam int ZW = 2 * WIDTH;

    logic [WIDTH-1:0] r_gpr [16];
    logic [WIDTH-1:0] r_hi, r_lo, r_pc, r_ir, r_mar, r_mdr, r_y;
    logic [ZW-1:0]    r_z;

    logic [WIDTH-1:0] w_bus, w_c, w_pc_plus_1;
    logic [WIDTH-1:0] w_a, w_b;
    logic [4:0]       w_sh;
    logic [5:0]       w_sh_c;
    logic [WIDTH-1:0] w_sum, w_diff, w_shr, w_sra, w_shl, w_ror, w_rol, w_neg;
    logic signed [WIDTH-1:0] w_quo, w_rem;
    logic signed [ZW-1:0]    w_prod;
    logic [ZW-1:0]    w_alu;

    assign w_c         = {{(WIDTH-19){r_ir[18]}}, r_ir[18:0]};
    assign w_pc_plus_1 = r_pc + 1'b1;

    // Lowest-priority source is written first so higher-priority strobes overwrite it.
    always_comb begin
        w_bus = '0;
        if (dp.MARout)   w_bus = r_mar;
        if (dp.Yout)     w_bus = r_y;
        if (dp.Cout)     w_bus = w_c;
        if (dp.INout)    w_bus = dp.IN;
        if (dp.MDRout)   w_bus = r_mdr;
        if (dp.IRout)    w_bus = r_ir;
        if (dp.PCout)    w_bus = r_pc;
        if (dp.Zlowout)  w_bus = r_z[WIDTH-1:0];
        if (dp.Zhighout) w_bus = r_z[ZW-1:WIDTH];
        if (dp.LOout)    w_bus = r_lo;
        if (dp.HIout)    w_bus = r_hi;
        for (int i = 15; i >= 0; i--) begin
            if (dp.Rout[i]) w_bus = r_gpr[i];
        end
    end

    assign w_a    = r_y;
    assign w_b    = w_bus;
    assign w_sh   = w_b[4:0];
    assign w_sh_c = 6'(WIDTH) - {1'b0, w_sh};

    assign w_sum  = w_a + w_b;
    assign w_diff = w_a - w_b;
    assign w_neg  = '0 - w_b;
    assign w_prod = $signed({{WIDTH{w_a[WIDTH-1]}}, w_a}) * $signed({{WIDTH{w_b[WIDTH-1]}}, w_b});
    assign w_quo  = $signed(w_a) / $signed(w_b);
    assign w_rem  = $signed(w_a) % $signed(w_b);
    assign w_shr  = w_a >> w_sh;
    assign w_sra  = WIDTH'($signed(w_a) >>> w_sh);
    assign w_shl  = w_a << w_sh;
    // A zero rotate gives a complementary shift of WIDTH, which contributes nothing.
    assign w_ror  = (w_a >> w_sh) | (w_a << w_sh_c);
    assign w_rol  = (w_a << w_sh) | (w_a >> w_sh_c);

    always_comb begin
        w_alu = '0;
        if (dp.ADD)       w_alu = {{WIDTH{w_sum[WIDTH-1]}}, w_sum};
        else if (dp.SUB)  w_alu = {{WIDTH{w_diff[WIDTH-1]}}, w_diff};
        else if (dp.AND)  w_alu = {{WIDTH{1'b0}}, w_a & w_b};
        else if (dp.OR)   w_alu = {{WIDTH{1'b0}}, w_a | w_b};
        else if (dp.MUL)  w_alu = w_prod;
        else if (dp.DIV)  w_alu = (w_b == '0) ? '0 : {w_rem, w_quo};
        else if (dp.SHR)  w_alu = {{WIDTH{1'b0}}, w_shr};
        else if (dp.SHRA) w_alu = {{WIDTH{1'b0}}, w_sra};
        else if (dp.SHL)  w_alu = {{WIDTH{1'b0}}, w_shl};
        else if (dp.ROR)  w_alu = {{WIDTH{1'b0}}, w_ror};
        else if (dp.ROL)  w_alu = {{WIDTH{1'b0}}, w_rol};
        else if (dp.NEG)  w_alu = {{WIDTH{1'b0}}, w_neg};
        else if (dp.NOT)  w_alu = {{WIDTH{1'b0}}, ~w_b};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_pc  <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_y   <= '0;
            r_z   <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (dp.Rin[i]) r_gpr[i] <= w_bus;
            end
            if (dp.HIin)  r_hi  <= w_bus;
            if (dp.LOin)  r_lo  <= w_bus;
            if (dp.IRin)  r_ir  <= w_bus;
            if (dp.Yin)   r_y   <= w_bus;
            if (dp.MARin) r_mar <= w_bus;
            if (dp.MDRin) r_mdr <= dp.Read ? dp.IN : w_bus;
            if (dp.PCin)  r_pc  <= dp.IncPC ? w_pc_plus_1 : w_bus;
            if (dp.Zin)   r_z   <= w_alu;
        end
    end

    assign dp.BusMuxOut = w_bus;
    assign dp.PC        = r_pc;
    assign dp.PC_PLUS_1 = w_pc_plus_1;
endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: directed scenarios plus randomized ALU ops against an arithmetic reference.
module tb_data_path;
    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    data_path_if #(.WIDTH(32)) dp_if ();
    data_path #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .dp(dp_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3, OP_MUL = 4, OP_DIV = 5,
                   OP_SHR = 6, OP_SHRA = 7, OP_SHL = 8, OP_ROR = 9, OP_ROL = 10,
                   OP_NEG = 11, OP_NOT = 12;

    task automatic clr();
        dp_if.Rout = '0; dp_if.HIout = 0; dp_if.LOout = 0; dp_if.Zhighout = 0; dp_if.Zlowout = 0;
        dp_if.PCout = 0; dp_if.IRout = 0; dp_if.MDRout = 0; dp_if.INout = 0; dp_if.Cout = 0;
        dp_if.Yout = 0; dp_if.MARout = 0;
        dp_if.Rin = '0; dp_if.HIin = 0; dp_if.LOin = 0; dp_if.PCin = 0; dp_if.IRin = 0;
        dp_if.Zin = 0; dp_if.Yin = 0; dp_if.MARin = 0; dp_if.MDRin = 0;
        dp_if.Read = 0; dp_if.IncPC = 0;
        dp_if.ADD = 0; dp_if.SUB = 0; dp_if.AND = 0; dp_if.OR = 0; dp_if.MUL = 0; dp_if.DIV = 0;
        dp_if.SHR = 0; dp_if.SHRA = 0; dp_if.SHL = 0; dp_if.ROR = 0; dp_if.ROL = 0;
        dp_if.NEG = 0; dp_if.NOT = 0;
        dp_if.IN = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic set_op(input int op);
        case (op)
            OP_ADD:  dp_if.ADD  = 1;
            OP_SUB:  dp_if.SUB  = 1;
            OP_AND:  dp_if.AND  = 1;
            OP_OR:   dp_if.OR   = 1;
            OP_MUL:  dp_if.MUL  = 1;
            OP_DIV:  dp_if.DIV  = 1;
            OP_SHR:  dp_if.SHR  = 1;
            OP_SHRA: dp_if.SHRA = 1;
            OP_SHL:  dp_if.SHL  = 1;
            OP_ROR:  dp_if.ROR  = 1;
            OP_ROL:  dp_if.ROL  = 1;
            OP_NEG:  dp_if.NEG  = 1;
            default: dp_if.NOT  = 1;
        endcase
    endtask

    // Reference ALU: plain signed 64-bit arithmetic and bit-by-bit rotation.
    function automatic logic [63:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        longint    sa = longint'($signed(a));
        longint    sb = longint'($signed(b));
        int        s  = int'(b[4:0]);
        longint    r;
        logic [31:0] t;
        case (op)
            OP_ADD:  begin r = sa + sb; t = r[31:0]; return longint'($signed(t)); end
            OP_SUB:  begin r = sa - sb; t = r[31:0]; return longint'($signed(t)); end
            OP_AND:  return {32'd0, a & b};
            OP_OR:   return {32'd0, a | b};
            OP_MUL:  return sa * sb;
            OP_DIV:  begin
                if (b == 0) return 64'd0;
                r = sa / sb;
                t = r[31:0];
                r = sa % sb;
                return {r[31:0], t};
            end
            OP_SHR:  return {32'd0, a >> s};
            OP_SHRA: begin r = sa >>> s; return {32'd0, r[31:0]}; end
            OP_SHL:  return {32'd0, a << s};
            OP_ROR:  begin for (int i = 0; i < 32; i++) t[i] = a[(i + s) % 32]; return {32'd0, t}; end
            OP_ROL:  begin for (int i = 0; i < 32; i++) t[(i + s) % 32] = a[i]; return {32'd0, t}; end
            OP_NEG:  begin r = 0 - sb; return {32'd0, r[31:0]}; end
            default: return {32'd0, ~b};
        endcase
    endfunction

    task automatic load_in_r(input int idx, input logic [31:0] v);
        dp_if.INout = 1; dp_if.IN = v; dp_if.Rin[idx] = 1;
        tick();
    endtask

    task automatic rd_r(input int idx, output logic [31:0] v);
        dp_if.Rout[idx] = 1; #1; v = dp_if.BusMuxOut; clr();
    endtask

    task automatic rd_z(output logic [63:0] z);
        dp_if.Zlowout = 1; #1; z[31:0] = dp_if.BusMuxOut; clr();
        dp_if.Zhighout = 1; #1; z[63:32] = dp_if.BusMuxOut; clr();
    endtask

    // Y <= a, then Z <= op(Y, b) with b driven from IN.
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b, output logic [63:0] z);
        dp_if.INout = 1; dp_if.IN = a; dp_if.Yin = 1;
        tick();
        dp_if.INout = 1; dp_if.IN = b; set_op(op); dp_if.Zin = 1;
        tick();
        rd_z(z);
    endtask

    task automatic test_reset();
        logic [63:0] z;
        reset = 0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        if (dp_if.PC !== 32'd0) begin $display("FAIL reset_pc got=%h exp=0", dp_if.PC); bad++; end
        total++;
        if (dp_if.PC_PLUS_1 !== 32'd1) begin $display("FAIL reset_pc1 got=%h exp=1", dp_if.PC_PLUS_1); bad++; end
        total++;
        @(negedge clk) reset = 1;
        @(posedge clk); #1;
        rd_z(z);
        if (z !== 64'd0) begin $display("FAIL reset_z got=%h exp=0", z); bad++; end
        total++;
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] v;
        logic [63:0] z;
        load_in_r(5, 32'h1234);
        dp_if.INout = 1; dp_if.IN = 32'd7; dp_if.PCin = 1; dp_if.Yin = 1;
        tick();
        dp_if.INout = 1; dp_if.IN = 32'd9; dp_if.ADD = 1; dp_if.Zin = 1;
        tick();
        rd_r(5, v);
        if (v !== 32'h1234 || dp_if.PC !== 32'd7) begin
            $display("FAIL pre_reset r5=%h pc=%h exp 1234/7", v, dp_if.PC); bad++;
        end
        total++;
        @(negedge clk);
        #2 reset = 0;
        #1;
        dp_if.Rout[5] = 1; #1;
        if (dp_if.BusMuxOut !== 32'd0) begin $display("FAIL midreset_r5 got=%h exp=0", dp_if.BusMuxOut); bad++; end
        total++;
        clr();
        if (dp_if.PC !== 32'd0 || dp_if.PC_PLUS_1 !== 32'd1) begin
            $display("FAIL midreset_pc pc=%h pc1=%h exp 0/1", dp_if.PC, dp_if.PC_PLUS_1); bad++;
        end
        total++;
        dp_if.Zlowout = 1; #1; z[31:0] = dp_if.BusMuxOut; clr();
        dp_if.Zhighout = 1; #1; z[63:32] = dp_if.BusMuxOut; clr();
        if (z !== 64'd0) begin $display("FAIL midreset_z got=%h exp=0", z); bad++; end
        total++;
        @(negedge clk) reset = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_mdr_load();
        logic [31:0] vals [3] = '{32'h22, 32'h24, 32'h28};
        int          regs [3] = '{3, 7, 4};
        logic [31:0] v;
        for (int k = 0; k < 3; k++) begin
            dp_if.IN = vals[k]; dp_if.Read = 1; dp_if.MDRin = 1;
            tick();
            dp_if.MDRout = 1; dp_if.Rin[regs[k]] = 1;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            rd_r(regs[k], v);
            if (v !== vals[k]) begin $display("FAIL mdr_load_r%0d got=%h exp=%h", regs[k], v, vals[k]); bad++; end
            total++;
        end
    endtask

    task automatic test_neg();
        logic [31:0] v;
        logic [63:0] z;
        dp_if.Rout[3] = 1; dp_if.Yin = 1;
        tick();
        dp_if.Rout[7] = 1; dp_if.NEG = 1; dp_if.Zin = 1;
        tick();
        dp_if.Zlowout = 1; dp_if.Rin[4] = 1;
        tick();
        rd_r(4, v);
        if (v !== 32'hFFFFFFDC) begin $display("FAIL neg_r4 got=%h exp=ffffffdc", v); bad++; end
        total++;
        rd_z(z);
        if (z[63:32] !== 32'd0) begin $display("FAIL neg_zhigh got=%h exp=0", z[63:32]); bad++; end
        total++;
    endtask

    task automatic test_fetch();
        logic [31:0] v, ir, c_exp;
        dp_if.INout = 1; dp_if.IN = 32'd0; dp_if.PCin = 1;
        tick();
        dp_if.IncPC = 1; dp_if.PCin = 1; dp_if.MARin = 1; dp_if.MDRin = 1; dp_if.Read = 1;
        dp_if.IN = 32'h2A2B8000;
        tick();
        if (dp_if.PC !== 32'd1) begin $display("FAIL fetch_pc got=%h exp=1", dp_if.PC); bad++; end
        total++;
        dp_if.MARout = 1; #1; v = dp_if.BusMuxOut; clr();
        if (v !== 32'd0) begin $display("FAIL fetch_mar got=%h exp=0", v); bad++; end
        total++;
        dp_if.MDRout = 1; dp_if.IRin = 1;
        tick();
        dp_if.IRout = 1; #1; ir = dp_if.BusMuxOut; clr();
        if (ir !== 32'h2A2B8000) begin $display("FAIL fetch_ir got=%h exp=2a2b8000", ir); bad++; end
        total++;
        c_exp = 32'($signed(ir[18:0]));
        dp_if.Cout = 1; #1; v = dp_if.BusMuxOut; clr();
        if (v !== c_exp) begin $display("FAIL c_sext got=%h exp=%h", v, c_exp); bad++; end
        total++;
        dp_if.IncPC = 1;
        tick();
        if (dp_if.PC !== 32'd1) begin $display("FAIL incpc_alone got=%h exp=1", dp_if.PC); bad++; end
        total++;
        dp_if.INout = 1; dp_if.IN = 32'hFFFFFFFF; dp_if.PCin = 1;
        tick();
        dp_if.PCin = 1; dp_if.IncPC = 1;
        tick();
        if (dp_if.PC !== 32'd0 || dp_if.PC_PLUS_1 !== 32'd1) begin
            $display("FAIL pc_wrap pc=%h pc1=%h exp 0/1", dp_if.PC, dp_if.PC_PLUS_1); bad++;
        end
        total++;
    endtask

    task automatic test_muldiv();
        logic [63:0] z;
        run_op(OP_MUL, 32'hFFFFFFFE, 32'd3, z);
        if (z !== 64'hFFFFFFFF_FFFFFFFA) begin $display("FAIL mul_neg got=%h exp=fffffffffffffffa", z); bad++; end
        total++;
        run_op(OP_DIV, 32'd7, 32'd2, z);
        if (z !== 64'h00000001_00000003) begin $display("FAIL div_7_2 got=%h exp=0000000100000003", z); bad++; end
        total++;
        run_op(OP_DIV, 32'd7, 32'd0, z);
        if (z !== 64'd0) begin $display("FAIL div_zero got=%h exp=0", z); bad++; end
        total++;
    endtask

    task automatic test_shifts();
        int          ops [5] = '{OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL};
        logic [31:0] exps [5] = '{32'h40000000, 32'hC0000000, 32'h00000002, 32'hC0000000, 32'h00000003};
        logic [63:0] z;
        for (int k = 0; k < 5; k++) begin
            run_op(ops[k], 32'h80000001, 32'd1, z);
            if (z !== {32'd0, exps[k]}) begin $display("FAIL shift_op%0d got=%h exp=%h", ops[k], z, exps[k]); bad++; end
            total++;
        end
    endtask

    task automatic test_priority();
        logic [31:0] v;
        logic [63:0] z;
        load_in_r(2, 32'hAAAA0002);
        load_in_r(9, 32'h99990009);
        dp_if.INout = 1; dp_if.IN = 32'h11112222; dp_if.HIin = 1;
        tick();
        dp_if.Rout[2] = 1; dp_if.Rout[9] = 1; #1; v = dp_if.BusMuxOut; clr();
        if (v !== 32'hAAAA0002) begin $display("FAIL prio_r2_r9 got=%h exp=aaaa0002", v); bad++; end
        total++;
        dp_if.Rout[9] = 1; dp_if.HIout = 1; #1; v = dp_if.BusMuxOut; clr();
        if (v !== 32'h99990009) begin $display("FAIL prio_r9_hi got=%h exp=99990009", v); bad++; end
        total++;
        dp_if.HIout = 1; dp_if.INout = 1; dp_if.IN = 32'd5; #1; v = dp_if.BusMuxOut; clr();
        if (v !== 32'h11112222) begin $display("FAIL prio_hi_in got=%h exp=11112222", v); bad++; end
        total++;
        #1;
        if (dp_if.BusMuxOut !== 32'd0) begin $display("FAIL bus_idle got=%h exp=0", dp_if.BusMuxOut); bad++; end
        total++;
        dp_if.INout = 1; dp_if.IN = 32'd10; dp_if.Yin = 1;
        tick();
        dp_if.INout = 1; dp_if.IN = 32'd3; dp_if.ADD = 1; dp_if.SUB = 1; dp_if.MUL = 1; dp_if.Zin = 1;
        tick();
        rd_z(z);
        if (z !== ref_alu(OP_ADD, 32'd10, 32'd3)) begin $display("FAIL op_prio got=%h exp=%h", z, ref_alu(OP_ADD, 32'd10, 32'd3)); bad++; end
        total++;
        dp_if.INout = 1; dp_if.IN = 32'd3; dp_if.Zin = 1;
        tick();
        rd_z(z);
        if (z !== 64'd0) begin $display("FAIL no_op_z got=%h exp=0", z); bad++; end
        total++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        dp_if.IN = 32'h5; dp_if.Read = 1; dp_if.MDRin = 1;
        tick();
        dp_if.MDRout = 1; dp_if.MDRin = 1; dp_if.Read = 1; dp_if.IN = 32'h77; dp_if.Rin[6] = 1;
        #1;
        if (dp_if.BusMuxOut !== 32'h5) begin $display("FAIL same_cycle_bus got=%h exp=5", dp_if.BusMuxOut); bad++; end
        total++;
        tick();
        rd_r(6, v);
        if (v !== 32'h5) begin $display("FAIL old_value_r6 got=%h exp=5", v); bad++; end
        total++;
        dp_if.MDRout = 1; #1; v = dp_if.BusMuxOut; clr();
        if (v !== 32'h77) begin $display("FAIL mdr_new got=%h exp=77", v); bad++; end
        total++;
    endtask

    task automatic test_random_alu();
        logic [31:0] a, b;
        logic [63:0] z, e;
        int          op;
        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 12);
            a  = $urandom;
            b  = $urandom;
            if (op >= OP_SHR && op <= OP_ROL) a = (k % 3 == 0) ? (a | 32'h80000000) : a;
            if (op == OP_DIV && $urandom_range(0, 5) == 0) b = 32'd0;
            if (op == OP_DIV && $urandom_range(0, 3) == 0) b = b >> $urandom_range(24, 31);
            if (op == OP_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            e = ref_alu(op, a, b);
            run_op(op, a, b, z);
            if (z !== e) begin $display("FAIL rand_op%0d a=%h b=%h got=%h exp=%h", op, a, b, z, e); bad++; end
            total++;
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_mdr_load();
        test_neg();
        test_fetch();
        test_muldiv();
        test_shifts();
        test_priority();
        test_back_to_back();
        test_random_alu();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
